dmem_ctrl: RTL and testbench

Parametrised byte-addressable data memory for the RISC-V core's load/store path, replacing the fixed 64-word, word-only data memory. Supports RV32I load/store sizes (byte, half, word) with sign/zero extension, byte-lane write merging, a valid/ready request port with a registered one-cycle response, and misalignment and out-of-range error reporting. After reset, a sequential init sweep clears the array one word per cycle before requests are accepted.

---
 rtl/dmem_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable RV32I data memory, valid/ready port, 1-cycle rsp.
// Optional macro DMEM_PRELOAD_EN: init sweep preloads word[15]=65, word[17]=56.
module dmem_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic                init_we;
  logic [31:0]         init_val;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   widx;
  logic [1:0]          lane;
  logic                oor, ill, mis, err;
  logic                is_b, is_h, is_w;
  logic                acc, wr_en;
  logic [3:0]          be;
  logic [31:0]         wd;
  logic [31:0]         rword;
  logic [7:0]          bsel;
  logic [15:0]         hsel;
  logic [31:0]         ldata;

  // State and sweep index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Sweep sequencing: one word cleared per INIT cycle
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    init_we   = 1'b0;
    init_val  = 32'd0;
    unique case (state)
      S_INIT: begin
        init_we = 1'b1;
        idx_nxt = idx + ADDR_W'(1);
`ifdef DMEM_PRELOAD_EN
        if (idx == ADDR_W'(15)) init_val = 32'd65;
        if (idx == ADDR_W'(17)) init_val = 32'd56;
`else
        init_val = 32'd0;
`endif
        if (idx == ADDR_W'(DEPTH - 1)) begin
          state_nxt = S_RUN;
          idx_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state == S_RUN);
  assign init_busy = (state == S_INIT);

  // Address decode, legality and lane enables
  always_comb begin
    widx  = req_addr[ADDR_W+1:2];
    lane  = req_addr[1:0];
    oor   = |req_addr[31:ADDR_W+2];
    is_b  = (req_funct3[1:0] == 2'b00);
    is_h  = (req_funct3[1:0] == 2'b01);
    is_w  = (req_funct3[1:0] == 2'b10);
    if (req_we)
      ill = (req_funct3 > 3'd2);
    else
      ill = (req_funct3 == 3'd3) ||
            (req_funct3[2:1] == 2'b11);
    mis = (is_h && lane[0]) || (is_w && (lane != 2'b00));
    err = oor || ill || mis;
    be  = 4'b0000;
    wd  = req_wdata;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
      end
      is_h: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      is_w: begin
        be = 4'b1111;
        wd = req_wdata;
      end
      default: ;
    endcase
  end

  assign acc   = req_valid && req_ready && !rst;
  assign wr_en = acc && req_we && !err;

  // Array write: sweep clears, stores merge selected lanes
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[idx] <= init_val;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  // Load lane extraction and extension
  always_comb begin
    rword = mem[widx];
    bsel  = rword[{lane, 3'b000} +: 8];
    hsel  = lane[1] ? rword[31:16] : rword[15:0];
    ldata = 32'd0;
    unique case (req_funct3)
      3'b000:  ldata = {{24{bsel[7]}}, bsel};
      3'b001:  ldata = {{16{hsel[15]}}, hsel};
      3'b010:  ldata = rword;
      3'b100:  ldata = {24'd0, bsel};
      3'b101:  ldata = {16'd0, hsel};
      default: ldata = 32'd0;
    endcase
  end

  // Registered response, held until the next accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= acc;
      if (acc) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? 32'd0 : ldata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector bench for dmem_ctrl.
// Table of requests plus init, idle and mid-run reset sequences.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int nvec = 0;
  int nerr = 0;

`ifdef DMEM_PRELOAD_EN
  localparam logic [31:0] W15 = 32'd65;
  localparam logic [31:0] W17 = 32'd56;
`else
  localparam logic [31:0] W15 = 32'd0;
  localparam logic [31:0] W17 = 32'd0;
`endif

  dmem_ctrl #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] w,
                              logic e, logic [31:0] r);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a;
    v.wdata = w; v.err = e; v.rdata = r;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = w;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    drive(v.we, v.f3, v.addr, v.wdata);
    @(posedge clk); #1;
    chk({nm, " valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, " err"},   32'(rsp_err),   32'(v.err));
    chk({nm, " rdata"}, rsp_rdata,      v.rdata);
  endtask

  task automatic wait_ready(input string nm, output int n,
                            output logic saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || rsp_err) saw_rsp = 1'b1;
      n = i;
      if (req_ready) break;
    end
    if (!req_ready) n = 999;
    chk({nm, " init cycles"}, 32'(n), 32'd64);
    chk({nm, " no rsp in init"}, 32'(saw_rsp), 32'd0);
  endtask

  initial begin
    int   n;
    logic saw;
    logic [31:0] last;

    // Power-on reset, two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst busy",  32'(init_busy), 32'd1);
    chk("rst valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", rsp_rdata,      32'd0);
    chk("rst err",   32'(rsp_err),   32'd0);

    // Hold a load request through the sweep; it must be ignored
    rst = 1'b0;
    drive(1'b0, 3'b010, 32'h3C, 32'd0);
    wait_ready("por", n, saw);
    chk("run busy", 32'(init_busy), 32'd0);

    tbl.push_back(mk(0, 3'b010, 32'h3C, 0, 0, W15));
    tbl.push_back(mk(1, 3'b010, 32'h08, 32'h11223344, 0, 0));
    tbl.push_back(mk(1, 3'b000, 32'h09, 32'h555555AA, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h08, 0, 0, 32'h1122AA44));
    tbl.push_back(mk(0, 3'b000, 32'h09, 0, 0, 32'hFFFFFFAA));
    tbl.push_back(mk(0, 3'b100, 32'h09, 0, 0, 32'h000000AA));
    tbl.push_back(mk(0, 3'b001, 32'h0A, 0, 0, 32'h00001122));
    tbl.push_back(mk(0, 3'b001, 32'h08, 0, 0, 32'hFFFFAA44));
    tbl.push_back(mk(0, 3'b101, 32'h08, 0, 0, 32'h0000AA44));
    tbl.push_back(mk(1, 3'b010, 32'h04, 32'h01020304, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h0A, 0, 1, 0));
    tbl.push_back(mk(1, 3'b001, 32'h05, 32'h5555, 1, 0));
    tbl.push_back(mk(0, 3'b010, 32'h04, 0, 0, 32'h01020304));
    tbl.push_back(mk(0, 3'b010, 32'h100, 0, 1, 0));
    tbl.push_back(mk(0, 3'b011, 32'h08, 0, 1, 0));
    tbl.push_back(mk(0, 3'b110, 32'h08, 0, 1, 0));
    tbl.push_back(mk(1, 3'b100, 32'h08, 32'hFFFFFFFF, 1, 0));
    tbl.push_back(mk(0, 3'b010, 32'h08, 0, 0, 32'h1122AA44));
    tbl.push_back(mk(1, 3'b001, 32'h0E, 32'h1234BEEF, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h0C, 0, 0, 32'hBEEF0000));
    tbl.push_back(mk(0, 3'b000, 32'h0F, 0, 0, 32'hFFFFFFBE));
    tbl.push_back(mk(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h20, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 3'b010, 32'hFC, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 32'hFC, 32'hCAFEF00D, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'hFC, 0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(1, 3'b010, 32'h02, 32'h12345678, 1, 0));
    tbl.push_back(mk(0, 3'b010, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h44, 0, 0, W17));
    tbl.push_back(mk(0, 3'b010, 32'h80000008, 0, 1, 0));

    // Back-to-back stream: every cycle must carry a response
    foreach (tbl[i]) run_vec($sformatf("v%0d", i), tbl[i]);
    last = tbl[tbl.size()-1].rdata;

    // Idle cycle: no response, data held
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle valid", 32'(rsp_valid), 32'd0);
    chk("idle hold",  rsp_rdata,      last);

    // Nonzero response, then reset with a store pending
    run_vec("pre rst", mk(0, 3'b010, 32'h20, 0, 0, 32'hDEADBEEF));
    rst = 1'b1;
    drive(1'b1, 3'b010, 32'h34, 32'h99);
    @(posedge clk); #1;
    chk("mid rst valid", 32'(rsp_valid), 32'd0);
    chk("mid rst rdata", rsp_rdata,      32'd0);
    chk("mid rst ready", 32'(req_ready), 32'd0);
    chk("mid rst busy",  32'(init_busy), 32'd1);
    rst = 1'b0;
    drive(1'b1, 3'b010, 32'h34, 32'h99);
    // One reset edge already counted into the sweep
    n = 0;
    saw = 1'b0;
    for (int i = 2; i <= 200; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1'b1;
      n = i;
      if (req_ready) break;
    end
    if (!req_ready) n = 999;
    chk("mid rst init cycles", 32'(n), 32'd65);
    chk("mid rst no rsp", 32'(saw), 32'd0);

    run_vec("clr 08", mk(0, 3'b010, 32'h08, 0, 0, 0));
    run_vec("clr 20", mk(0, 3'b010, 32'h20, 0, 0, 0));
    run_vec("clr 34", mk(0, 3'b010, 32'h34, 0, 0, 0));
    run_vec("clr FC", mk(0, 3'b010, 32'hFC, 0, 0, 0));
    run_vec("clr 3C", mk(0, 3'b010, 32'h3C, 0, 0, W15));
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("end valid", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
